// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request queue.
//  NUM_FLOORS  floors served (codes 1..NUM_FLOORS)
//  FLOOR_W     width of a floor code
//  FLOOR_NONE  "no request" floor code
//  DIR_UP/DIR_DOWN  encoding of the car direction input
//  state_t     request-queue FSM state encoding
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 7;
    localparam int unsigned FLOOR_W    = 3;

    localparam logic [FLOOR_W-1:0] FLOOR_NONE = 3'd0;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/elevator_request_queue_if.sv
// Bus between the elevator controller side and the request queue.
//  btn        floor button presses, bit i-1 = floor i       (master -> slave)
//  cur_floor  car position                                  (master -> slave)
//  direction  car direction, DIR_UP / DIR_DOWN              (master -> slave)
//  arrived    car is at its requested floor                 (master -> slave)
//  from       issued target floor, FLOOR_NONE when idle     (slave -> master)
//  pending    pending-request bitmap                        (slave -> master)
//  busy       queue FSM not idle                            (slave -> master)
//  served_cnt saturating count of completed requests        (slave -> master)
interface elevator_request_queue_if
    import elevator_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);
    logic [NUM_FLOORS-1:0] btn;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  direction;
    logic                  arrived;
    logic [FLOOR_W-1:0]    from;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;
    logic [CNT_W-1:0]      served_cnt;

    modport master (
        output btn, cur_floor, direction, arrived,
        input  from, pending, busy, served_cnt
    );

    modport slave (
        input  btn, cur_floor, direction, arrived,
        output from, pending, busy, served_cnt
    );
endinterface

// File: rtl/elevator_floor_select.sv
// Combinational SCAN picker: chooses the next floor to serve from the
// pending bitmap given the car position and direction.
//  i_pending    pending bitmap, bit i-1 = floor i
//  i_cur_floor  car position
//  i_direction  DIR_UP / DIR_DOWN
//  o_sel_c      selected floor, FLOOR_NONE when nothing pending
//  o_sel_valid_c  1 when o_sel_c is a real floor
module elevator_floor_select
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_cur_floor,
    input  logic                  i_direction,
    output logic [FLOOR_W-1:0]    o_sel_c,
    output logic                  o_sel_valid_c
);

    logic [FLOOR_W-1:0] w_up_ge;   // lowest pending >= cur
    logic [FLOOR_W-1:0] w_up_lt;   // highest pending < cur
    logic [FLOOR_W-1:0] w_dn_le;   // highest pending <= cur
    logic [FLOOR_W-1:0] w_dn_gt;   // lowest pending > cur
    logic [FLOOR_W-1:0] w_fl;

    // Floor codes start at 1, so FLOOR_NONE doubles as "not found".
    always_comb begin
        w_up_ge = FLOOR_NONE;
        w_up_lt = FLOOR_NONE;
        w_dn_le = FLOOR_NONE;
        w_dn_gt = FLOOR_NONE;
        w_fl    = FLOOR_NONE;
        // Descending scan: the last hit is the lowest floor.
        for (int f = NUM_FLOORS; f >= 1; f--) begin
            w_fl = FLOOR_W'(f);
            if (i_pending[f-1] && (w_fl >= i_cur_floor)) w_up_ge = w_fl;
            if (i_pending[f-1] && (w_fl >  i_cur_floor)) w_dn_gt = w_fl;
        end
        // Ascending scan: the last hit is the highest floor.
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            w_fl = FLOOR_W'(f);
            if (i_pending[f-1] && (w_fl <  i_cur_floor)) w_up_lt = w_fl;
            if (i_pending[f-1] && (w_fl <= i_cur_floor)) w_dn_le = w_fl;
        end
    end

    // Prefer floors ahead of the car, otherwise reverse.
    always_comb begin
        o_sel_c = FLOOR_NONE;
        case (i_direction)
            DIR_UP:   o_sel_c = (w_up_ge != FLOOR_NONE) ? w_up_ge : w_up_lt;
            DIR_DOWN: o_sel_c = (w_dn_le != FLOOR_NONE) ? w_dn_le : w_dn_gt;
            default:  o_sel_c = FLOOR_NONE;
        endcase
        o_sel_valid_c = (o_sel_c != FLOOR_NONE);
    end

endmodule

// File: rtl/elevator_request_queue.sv
// Elevator request queue: latches hall-button presses, picks the next
// target with SCAN, holds it on 'from' until arrival, then dwells.
//  clk    clock, all state on posedge
//  reset  synchronous active-high reset
//  bus    elevator_request_queue_if slave modport
//         (btn, cur_floor, direction, arrived in; from, pending, busy, served_cnt out)
module elevator_request_queue
    import elevator_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 2,
    parameter int unsigned CNT_W        = 8
)(
    input  logic                      clk,
    input  logic                      reset,
    elevator_request_queue_if.slave   bus
);

    localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t                r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [FLOOR_W-1:0]    r_target;
    logic [FLOOR_W-1:0]    r_from;
    logic [DW_W-1:0]       r_dwell;
    logic [CNT_W-1:0]      r_served;
    logic                  r_busy;

    logic [FLOOR_W-1:0]    w_sel;
    logic                  w_sel_valid;
    logic                  w_hit;
    logic [NUM_FLOORS-1:0] w_clr_mask;

    elevator_floor_select u_select (
        .i_pending     (r_pending),
        .i_cur_floor   (bus.cur_floor),
        .i_direction   (bus.direction),
        .o_sel_c       (w_sel),
        .o_sel_valid_c (w_sel_valid)
    );

    // Arrival only counts at the frozen target floor.
    assign w_hit = (r_state == SERVE) && bus.arrived && (bus.cur_floor == r_target);

    // One-hot clear of the served floor.
    always_comb begin
        w_clr_mask = '0;
        if (w_hit) begin
            for (int f = 1; f <= NUM_FLOORS; f++) begin
                if (FLOOR_W'(f) == r_target) w_clr_mask[f-1] = 1'b1;
            end
        end
    end

    // Pending capture (set wins over clear) and request FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_target  <= FLOOR_NONE;
            r_from    <= FLOOR_NONE;
            r_dwell   <= '0;
            r_served  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | bus.btn;
            case (r_state)
                IDLE: begin
                    if (w_sel_valid) begin
                        r_target <= w_sel;
                        r_from   <= w_sel;
                        r_state  <= SERVE;
                        r_busy   <= 1'b1;
                    end else begin
                        r_from   <= FLOOR_NONE;
                    end
                end
                SERVE: begin
                    if (w_hit) begin
                        r_from <= FLOOR_NONE;
                        if (r_served != '1) r_served <= r_served + CNT_W'(1);
                        if (DWELL_CYCLES > 0) begin
                            r_dwell <= DW_W'(DWELL_CYCLES - 1);
                            r_state <= DWELL;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DWELL: begin
                    r_from <= FLOOR_NONE;
                    if (r_dwell == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dwell <= r_dwell - DW_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_from  <= FLOOR_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.from       = r_from;
    assign bus.pending    = r_pending;
    assign bus.busy       = r_busy;
    assign bus.served_cnt = r_served;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Self-checking bench for elevator_request_queue (DWELL_CYCLES=2, CNT_W=8).
module tb_elevator_request_queue;
    import elevator_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    elevator_request_queue_if #(.CNT_W(8)) bus ();

    elevator_request_queue #(
        .DWELL_CYCLES (2),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic [6:0] btn;
        logic [2:0] cur;
        logic       dir;
        logic       arr;
        logic [2:0] e_from;
        logic [6:0] e_pend;
        logic       e_busy;
        logic [7:0] e_srv;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [6:0] btn, input logic [2:0] cur,
                         input logic dir, input logic arr);
        reset         = rst;
        bus.btn       = btn;
        bus.cur_floor = cur;
        bus.direction = dir;
        bus.arrived   = arr;
    endtask

    initial begin
        drive(1'b1, 7'h00, 3'd0, 1'b0, 1'b0);

        //          rst  btn    cur   dir   arr  | from  pend   busy  served
        vecs[0]  = '{1'b1, 7'h00, 3'd0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 8'd0};
        // floor 3 from floor 1, then arrival
        vecs[1]  = '{1'b0, 7'h04, 3'd1, 1'b0, 1'b0, 3'd0, 7'h04, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 7'h00, 3'd1, 1'b0, 1'b0, 3'd3, 7'h04, 1'b1, 8'd0};
        vecs[3]  = '{1'b0, 7'h00, 3'd3, 1'b0, 1'b1, 3'd0, 7'h00, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 7'h00, 3'd3, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 8'd1};
        vecs[5]  = '{1'b0, 7'h00, 3'd3, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 8'd1};
        // up-scan: {2,5,6} at floor 4 -> 5, 6, 2
        vecs[6]  = '{1'b0, 7'h32, 3'd4, 1'b0, 1'b0, 3'd0, 7'h32, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 7'h00, 3'd4, 1'b0, 1'b0, 3'd5, 7'h32, 1'b1, 8'd1};
        vecs[8]  = '{1'b0, 7'h00, 3'd5, 1'b0, 1'b1, 3'd0, 7'h22, 1'b1, 8'd2};
        vecs[9]  = '{1'b0, 7'h00, 3'd5, 1'b0, 1'b0, 3'd0, 7'h22, 1'b1, 8'd2};
        vecs[10] = '{1'b0, 7'h00, 3'd5, 1'b0, 1'b0, 3'd0, 7'h22, 1'b0, 8'd2};
        vecs[11] = '{1'b0, 7'h00, 3'd5, 1'b0, 1'b0, 3'd6, 7'h22, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 7'h00, 3'd6, 1'b0, 1'b1, 3'd0, 7'h02, 1'b1, 8'd3};
        vecs[13] = '{1'b0, 7'h00, 3'd6, 1'b0, 1'b0, 3'd0, 7'h02, 1'b1, 8'd3};
        vecs[14] = '{1'b0, 7'h00, 3'd6, 1'b0, 1'b0, 3'd0, 7'h02, 1'b0, 8'd3};
        vecs[15] = '{1'b0, 7'h00, 3'd6, 1'b0, 1'b0, 3'd2, 7'h02, 1'b1, 8'd3};
        // arrived at the wrong floor is ignored
        vecs[16] = '{1'b0, 7'h00, 3'd4, 1'b0, 1'b1, 3'd2, 7'h02, 1'b1, 8'd3};
        vecs[17] = '{1'b0, 7'h00, 3'd2, 1'b0, 1'b1, 3'd0, 7'h00, 1'b1, 8'd4};
        vecs[18] = '{1'b0, 7'h00, 3'd2, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 8'd4};
        vecs[19] = '{1'b0, 7'h00, 3'd2, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 8'd4};
        // down-scan fallback: {6} at floor 4 going down -> 6
        vecs[20] = '{1'b0, 7'h20, 3'd4, 1'b1, 1'b0, 3'd0, 7'h20, 1'b0, 8'd4};
        vecs[21] = '{1'b0, 7'h00, 3'd4, 1'b1, 1'b0, 3'd6, 7'h20, 1'b1, 8'd4};
        vecs[22] = '{1'b0, 7'h00, 3'd6, 1'b1, 1'b1, 3'd0, 7'h00, 1'b1, 8'd5};
        vecs[23] = '{1'b0, 7'h00, 3'd6, 1'b1, 1'b0, 3'd0, 7'h00, 1'b1, 8'd5};
        vecs[24] = '{1'b0, 7'h00, 3'd6, 1'b1, 1'b0, 3'd0, 7'h00, 1'b0, 8'd5};
        // down-scan: {2,6} at floor 4 going down -> 2, then 6
        vecs[25] = '{1'b0, 7'h22, 3'd4, 1'b1, 1'b0, 3'd0, 7'h22, 1'b0, 8'd5};
        vecs[26] = '{1'b0, 7'h00, 3'd4, 1'b1, 1'b0, 3'd2, 7'h22, 1'b1, 8'd5};
        vecs[27] = '{1'b0, 7'h00, 3'd2, 1'b1, 1'b1, 3'd0, 7'h20, 1'b1, 8'd6};
        vecs[28] = '{1'b0, 7'h00, 3'd2, 1'b1, 1'b0, 3'd0, 7'h20, 1'b1, 8'd6};
        vecs[29] = '{1'b0, 7'h00, 3'd2, 1'b1, 1'b0, 3'd0, 7'h20, 1'b0, 8'd6};
        vecs[30] = '{1'b0, 7'h00, 3'd2, 1'b1, 1'b0, 3'd6, 7'h20, 1'b1, 8'd6};
        vecs[31] = '{1'b0, 7'h00, 3'd6, 1'b1, 1'b1, 3'd0, 7'h00, 1'b1, 8'd7};
        vecs[32] = '{1'b0, 7'h00, 3'd6, 1'b1, 1'b0, 3'd0, 7'h00, 1'b1, 8'd7};
        vecs[33] = '{1'b0, 7'h00, 3'd6, 1'b1, 1'b0, 3'd0, 7'h00, 1'b0, 8'd7};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].btn, vecs[i].cur, vecs[i].dir, vecs[i].arr);
            step();
            check($sformatf("v%0d_from", i),    32'(bus.from),       32'(vecs[i].e_from));
            check($sformatf("v%0d_pending", i), 32'(bus.pending),    32'(vecs[i].e_pend));
            check($sformatf("v%0d_busy", i),    32'(bus.busy),       32'(vecs[i].e_busy));
            check($sformatf("v%0d_served", i),  32'(bus.served_cnt), 32'(vecs[i].e_srv));
        end

        // Set wins: floor 5 pressed in its own clear cycle is re-issued after dwell.
        drive(1'b0, 7'h10, 3'd1, 1'b0, 1'b0);
        step();
        check("setwin_pend0", 32'(bus.pending), 32'h10);
        drive(1'b0, 7'h00, 3'd1, 1'b0, 1'b0);
        step();
        check("setwin_issue", 32'(bus.from), 32'd5);
        drive(1'b0, 7'h10, 3'd5, 1'b0, 1'b1);
        step();
        check("setwin_pend_kept", 32'(bus.pending), 32'h10);
        check("setwin_from_zero", 32'(bus.from), 32'd0);
        check("setwin_served", 32'(bus.served_cnt), 32'd8);
        drive(1'b0, 7'h00, 3'd5, 1'b0, 1'b0);
        step();
        check("setwin_dwell1", 32'(bus.from), 32'd0);
        step();
        check("setwin_dwell2", 32'(bus.from), 32'd0);
        step();
        check("setwin_reissue", 32'(bus.from), 32'd5);
        drive(1'b0, 7'h00, 3'd5, 1'b0, 1'b1);
        step();
        check("setwin_done_pend", 32'(bus.pending), 32'h00);
        check("setwin_done_srv", 32'(bus.served_cnt), 32'd9);
        drive(1'b0, 7'h00, 3'd5, 1'b0, 1'b0);
        step();
        step();
        check("setwin_idle", 32'(bus.busy), 32'd0);

        // Reset during SERVE with target 7; press in the reset cycle is dropped.
        drive(1'b0, 7'h40, 3'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 7'h00, 3'd1, 1'b0, 1'b0);
        step();
        check("rst_serve_from", 32'(bus.from), 32'd7);
        check("rst_serve_busy", 32'(bus.busy), 32'd1);
        drive(1'b1, 7'h01, 3'd1, 1'b0, 1'b0);
        step();
        check("rst_from",    32'(bus.from),       32'd0);
        check("rst_pending", 32'(bus.pending),    32'h00);
        check("rst_busy",    32'(bus.busy),       32'd0);
        check("rst_served",  32'(bus.served_cnt), 32'd0);
        drive(1'b0, 7'h00, 3'd1, 1'b0, 1'b0);
        step();
        check("rst_drop_pend", 32'(bus.pending), 32'h00);
        check("rst_drop_from", 32'(bus.from),    32'd0);

        // Saturation: 260 serves at the current floor must stop at 255.
        for (int n = 0; n < 260; n++) begin
            drive(1'b0, 7'h01, 3'd1, 1'b0, 1'b0);
            step();
            drive(1'b0, 7'h00, 3'd1, 1'b0, 1'b0);
            step();
            drive(1'b0, 7'h00, 3'd1, 1'b0, 1'b1);
            step();
            drive(1'b0, 7'h00, 3'd1, 1'b0, 1'b0);
            step();
            step();
            if (n == 9) check("count_10", 32'(bus.served_cnt), 32'd10);
        end
        check("sat_served", 32'(bus.served_cnt), 32'd255);
        check("sat_busy",   32'(bus.busy),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
